// File: rtl/tile_rom_sdr_arbiter_if.sv
// ---------------------------------------------------------------------------
// tile_rom_sdr_arbiter_if
//   ROM read port between the tile/sprite fetch arbiter and the SDRAM
//   controller.
//
//   sdr_addr : byte address of the requested word (arbiter -> controller)
//   sdr_req  : 1-cycle read request pulse        (arbiter -> controller)
//   sdr_rdy  : 1-cycle read-data-valid pulse      (controller -> arbiter)
//   sdr_data : read data, valid with sdr_rdy      (controller -> arbiter)
//
//   modport master : arbiter side
//   modport slave  : SDRAM controller side
// ---------------------------------------------------------------------------
interface tile_rom_sdr_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_req;
  logic              sdr_rdy;
  logic [DATA_W-1:0] sdr_data;

  modport master (
    output sdr_addr,
    output sdr_req,
    input  sdr_rdy,
    input  sdr_data
  );

  modport slave (
    input  sdr_addr,
    input  sdr_req,
    output sdr_rdy,
    output sdr_data
  );
endinterface

// File: rtl/tile_rom_sdr_arbiter.sv
// ---------------------------------------------------------------------------
// tile_rom_sdr_arbiter
//   Shares one SDRAM ROM read port among NCH graphics layers. Each channel
//   strobes a word address; repeated fetches of the last completed address
//   are answered locally (hit), a strobe at the in-flight address merges into
//   the running fetch, and anything else becomes the channel's pending
//   request (latest address wins). Pending requests are granted round-robin,
//   one transaction outstanding at a time; a fetch that sees no sdr_rdy for
//   TIMEOUT cycles is re-issued at the same address, without limit.
//
//   clk       : system clock, all logic on posedge
//   RESETn    : asynchronous active-low reset
//   ch_strobe : per-channel 1-cycle fetch request
//   ch_addr   : per-channel word address, sampled with ch_strobe
//   ch_data   : per-channel last fetched word, held until next completion
//   ch_valid  : per-channel 1-cycle pulse on completion or hit
//   ch_busy   : per-channel pending-or-in-flight flag
//   sdr       : SDRAM ROM read port (master side)
// ---------------------------------------------------------------------------
module tile_rom_sdr_arbiter #(
  parameter int                    NCH       = 4,
  parameter int                    REQ_AW    = 18,
  parameter int                    ADDR_W    = 25,
  parameter int                    DATA_W    = 16,
  parameter logic [NCH*ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                    TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  RESETn,
  input  logic [NCH-1:0]        ch_strobe,
  input  logic [NCH*REQ_AW-1:0] ch_addr,
  output logic [NCH*DATA_W-1:0] ch_data,
  output logic [NCH-1:0]        ch_valid,
  output logic [NCH-1:0]        ch_busy,
  tile_rom_sdr_arbiter_if.master sdr
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  // Control state (reset)
  state_e                state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NCH-1:0]        pend_valid_q, pend_valid_d;
  logic [NCH-1:0]        last_valid_q, last_valid_d;
  logic [NCH-1:0]        inflight_q, inflight_d;
  logic [NCH-1:0]        ch_valid_q, ch_valid_d;
  logic [NCH*DATA_W-1:0] ch_data_q, ch_data_d;
  logic                  sdr_req_q, sdr_req_d;
  logic [ADDR_W-1:0]     sdr_addr_q, sdr_addr_d;

  // Address storage (no reset, always qualified by a valid flag)
  logic [REQ_AW-1:0]     pend_addr_q [NCH];
  logic [REQ_AW-1:0]     pend_addr_d [NCH];
  logic [REQ_AW-1:0]     last_addr_q [NCH];
  logic [REQ_AW-1:0]     last_addr_d [NCH];
  logic [REQ_AW-1:0]     fl_addr_q, fl_addr_d;

  // Round-robin pick: first pending channel at or after rr_ptr, cyclic.
  logic            arb_found;
  logic [CH_W-1:0] arb_ch;

  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!arb_found && pend_valid_q[(int'(rr_ptr_q) + k) % NCH]) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'((int'(rr_ptr_q) + k) % NCH);
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    last_valid_d = last_valid_q;
    inflight_d   = inflight_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    sdr_req_d    = 1'b0;
    sdr_addr_d   = sdr_addr_q;
    pend_addr_d  = pend_addr_q;
    last_addr_d  = last_addr_q;
    fl_addr_d    = fl_addr_q;

    unique case (state_q)
      S_IDLE: begin
        // sdr_rdy is deliberately ignored here: no response is owed.
        if (arb_found) begin
          sdr_req_d            = 1'b1;
          sdr_addr_d           = BASE_ADDR[int'(arb_ch)*ADDR_W +: ADDR_W]
                               | ADDR_W'({pend_addr_q[arb_ch], 1'b0});
          pend_valid_d[arb_ch] = 1'b0;
          inflight_d[arb_ch]   = 1'b1;
          fl_addr_d            = pend_addr_q[arb_ch];
          gnt_d                = arb_ch;
          rr_ptr_d             = (int'(arb_ch) == NCH - 1) ? '0 : arb_ch + 1'b1;
          cnt_d                = '0;
          state_d              = S_WAIT;
        end
      end

      S_WAIT: begin
        if (sdr.sdr_rdy) begin
          ch_data_d[int'(gnt_q)*DATA_W +: DATA_W] = sdr.sdr_data;
          ch_valid_d[gnt_q]   = 1'b1;
          last_addr_d[gnt_q]  = fl_addr_q;
          last_valid_d[gnt_q] = 1'b1;
          inflight_d[gnt_q]   = 1'b0;
          state_d             = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Lost response: re-issue at the unchanged sdr_addr.
          sdr_req_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes are applied after the grant so that a strobe arriving in the
    // grant cycle re-arms pending after the grant has consumed the old one.
    for (int i = 0; i < NCH; i++) begin
      if (ch_strobe[i]) begin
        if (inflight_q[i] && ch_addr[i*REQ_AW +: REQ_AW] == fl_addr_q) begin
          // Merged into the running fetch; its completion answers this too.
        end else if (last_valid_q[i] && !pend_valid_q[i] &&
                     ch_addr[i*REQ_AW +: REQ_AW] == last_addr_q[i]) begin
          ch_valid_d[i] = 1'b1;
        end else begin
          pend_valid_d[i] = 1'b1;
          pend_addr_d[i]  = ch_addr[i*REQ_AW +: REQ_AW];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      pend_valid_q <= '0;
      last_valid_q <= '0;
      inflight_q   <= '0;
      ch_valid_q   <= '0;
      ch_data_q    <= '0;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      last_valid_q <= last_valid_d;
      inflight_q   <= inflight_d;
      ch_valid_q   <= ch_valid_d;
      ch_data_q    <= ch_data_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
    end
  end

  // NOTE: the address arrays are left out of reset on purpose; each entry is
  // only read while its valid/inflight flag is set, and those flags do reset.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    last_addr_q <= last_addr_d;
    fl_addr_q   <= fl_addr_d;
  end

  assign ch_data      = ch_data_q;
  assign ch_valid     = ch_valid_q;
  assign ch_busy      = pend_valid_q | inflight_q;
  assign sdr.sdr_req  = sdr_req_q;
  assign sdr.sdr_addr = sdr_addr_q;

endmodule

// File: tb/tb_tile_rom_sdr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tile_rom_sdr_arbiter
//   Directed bench for tile_rom_sdr_arbiter (NCH=4, TIMEOUT=8). Expected
//   SDRAM addresses and expected completions are queued when stimulus is
//   driven and consumed whenever the DUT pulses sdr_req / ch_valid.
// ---------------------------------------------------------------------------
module tb_tile_rom_sdr_arbiter;

  localparam int NCH    = 4;
  localparam int REQ_AW = 18;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam logic [NCH*ADDR_W-1:0] BASE = {25'h1000000, 25'h0800000,
                                            25'h0100000, 25'h0080000};

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } cpl_t;

  logic                  clk = 1'b0;
  logic                  RESETn;
  logic [NCH-1:0]        ch_strobe;
  logic [NCH*REQ_AW-1:0] ch_addr;
  logic [NCH*DATA_W-1:0] ch_data;
  logic [NCH-1:0]        ch_valid;
  logic [NCH-1:0]        ch_busy;

  tile_rom_sdr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sdr_if ();

  tile_rom_sdr_arbiter #(
    .NCH(NCH), .REQ_AW(REQ_AW), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BASE_ADDR(BASE), .TIMEOUT(8)
  ) dut (
    .clk(clk), .RESETn(RESETn),
    .ch_strobe(ch_strobe), .ch_addr(ch_addr),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_busy(ch_busy),
    .sdr(sdr_if)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_pass   = 0;
  int                n_fail   = 0;
  int                req_cnt  = 0;
  int                vld_cnt [NCH];
  logic [DATA_W-1:0] exp_data [NCH];
  logic [ADDR_W-1:0] exp_addr_q [$];
  cpl_t              exp_cpl_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT produced.
  task automatic tick();
    cpl_t c;
    @(negedge clk);
    if (sdr_if.sdr_req === 1'b1) begin
      req_cnt++;
      check("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
      if (exp_addr_q.size() != 0)
        check("sdr_addr", 64'(sdr_if.sdr_addr), 64'(exp_addr_q.pop_front()));
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i] === 1'b1) begin
        vld_cnt[i]++;
        check("cpl_expected", 64'(exp_cpl_q.size() != 0), 64'd1);
        if (exp_cpl_q.size() != 0) begin
          c = exp_cpl_q.pop_front();
          check("cpl_ch", 64'(i), 64'(c.ch));
          check("ch_data", 64'(ch_data[i*DATA_W +: DATA_W]), 64'(c.data));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe1(input int ch, input logic [REQ_AW-1:0] a);
    ch_strobe[ch]                 = 1'b1;
    ch_addr[ch*REQ_AW +: REQ_AW] = a;
    tick();
    ch_strobe = '0;
  endtask

  // Bounded wait for the next sdr_req; n returns the ticks it took.
  task automatic wait_req(input int budget, output int n);
    int start;
    start = req_cnt;
    n     = 0;
    while (req_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check("req_arrival", 64'(req_cnt != start), 64'd1);
  endtask

  // One-cycle sdr_rdy answering the fetch of channel ch.
  task automatic serve(input int ch, input logic [DATA_W-1:0] d);
    exp_data[ch] = d;
    exp_cpl_q.push_back('{ch, d});
    sdr_if.sdr_data = d;
    sdr_if.sdr_rdy  = 1'b1;
    tick();
    sdr_if.sdr_rdy  = 1'b0;
    for (int i = 0; i < NCH; i++)
      check("ch_data_hold", 64'(ch_data[i*DATA_W +: DATA_W]), 64'(exp_data[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int req0;
    int vld0;

    RESETn          = 1'b0;
    ch_strobe       = '0;
    ch_addr         = '0;
    sdr_if.sdr_rdy  = 1'b0;
    sdr_if.sdr_data = '0;
    for (int i = 0; i < NCH; i++) begin
      vld_cnt[i]  = 0;
      exp_data[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sdr_req", 64'(sdr_if.sdr_req), 64'd0);
    check("rst_sdr_addr", 64'(sdr_if.sdr_addr), 64'd0);
    check("rst_ch_valid", 64'(ch_valid), 64'd0);
    check("rst_ch_busy", 64'(ch_busy), 64'd0);
    check("rst_ch_data", 64'(ch_data), 64'd0);
    RESETn = 1'b1;
    idle(2);

    // Single fetch: ch1 0x00123 -> 0x0100246, request two cycles after strobe
    exp_addr_q.push_back(25'h0100246);
    strobe1(1, 18'h00123);
    check("busy_pending", 64'(ch_busy), 64'b0010);
    wait_req(10, n);
    check("req_latency", 64'(n), 64'd1);
    check("busy_inflight", 64'(ch_busy), 64'b0010);
    serve(1, 16'hBEEF);
    check("busy_done", 64'(ch_busy), 64'd0);
    idle(2);

    // Hit: same address answered locally, no SDRAM access
    req0 = req_cnt;
    vld0 = vld_cnt[1];
    exp_cpl_q.push_back('{1, 16'hBEEF});
    strobe1(1, 18'h00123);
    check("hit_valid_next", 64'(vld_cnt[1] - vld0), 64'd1);
    idle(4);
    check("hit_no_req", 64'(req_cnt - req0), 64'd0);
    check("hit_busy", 64'(ch_busy), 64'd0);

    // Round-robin: ch0, ch2, ch3 together with rr_ptr=2 -> order 2, 3, 0
    exp_addr_q.push_back(25'h0800154);
    exp_addr_q.push_back(25'h107FFFE);
    exp_addr_q.push_back(25'h008000A);
    ch_strobe = 4'b1101;
    ch_addr[0*REQ_AW +: REQ_AW] = 18'h00005;
    ch_addr[2*REQ_AW +: REQ_AW] = 18'h000AA;
    ch_addr[3*REQ_AW +: REQ_AW] = 18'h3FFFF;
    tick();
    ch_strobe = '0;
    check("rr_busy", 64'(ch_busy), 64'b1101);
    wait_req(10, n);
    idle(3);
    serve(2, 16'h2222);
    wait_req(10, n);
    check("rr_spacing_3", 64'(n), 64'd1);
    serve(3, 16'h3333);
    wait_req(10, n);
    check("rr_spacing_0", 64'(n), 64'd1);
    serve(0, 16'h0000);
    idle(3);
    check("rr_done_busy", 64'(ch_busy), 64'd0);

    // Latest-wins and merge on ch0
    req0 = req_cnt;
    vld0 = vld_cnt[0];
    exp_addr_q.push_back(25'h0080020);
    strobe1(0, 18'h00010);
    wait_req(10, n);
    strobe1(0, 18'h00020);
    strobe1(0, 18'h00030);
    strobe1(0, 18'h00010);
    check("lw_busy", 64'(ch_busy), 64'b0001);
    exp_addr_q.push_back(25'h0080060);
    serve(0, 16'h1010);
    wait_req(10, n);
    serve(0, 16'h3030);
    idle(6);
    check("lw_req_count", 64'(req_cnt - req0), 64'd2);
    check("lw_valid_count", 64'(vld_cnt[0] - vld0), 64'd2);
    check("lw_busy_done", 64'(ch_busy), 64'd0);

    // Timeout re-issue every 8 cycles, answered on the third attempt
    repeat (3) exp_addr_q.push_back(25'h1000EEE);
    strobe1(3, 18'h00777);
    wait_req(10, n);
    wait_req(20, n);
    check("retry_period_1", 64'(n), 64'd8);
    wait_req(20, n);
    check("retry_period_2", 64'(n), 64'd8);
    serve(3, 16'hCAFE);
    idle(12);
    check("retry_stopped", 64'(exp_addr_q.size()), 64'd0);

    // Reset mid-WAIT
    exp_addr_q.push_back(25'h0800176);
    strobe1(2, 18'h000BB);
    wait_req(10, n);
    RESETn = 1'b0;
    #1;
    check("mid_rst_sdr_req", 64'(sdr_if.sdr_req), 64'd0);
    check("mid_rst_sdr_addr", 64'(sdr_if.sdr_addr), 64'd0);
    check("mid_rst_ch_busy", 64'(ch_busy), 64'd0);
    check("mid_rst_ch_data", 64'(ch_data), 64'd0);
    check("mid_rst_ch_valid", 64'(ch_valid), 64'd0);
    for (int i = 0; i < NCH; i++) exp_data[i] = '0;
    tick();
    RESETn = 1'b1;
    tick();
    vld0 = vld_cnt[2];
    sdr_if.sdr_data = 16'hDEAD;
    sdr_if.sdr_rdy  = 1'b1;
    tick();
    sdr_if.sdr_rdy  = 1'b0;
    idle(3);
    check("late_rdy_ignored", 64'(vld_cnt[2] - vld0), 64'd0);
    check("late_rdy_data", 64'(ch_data), 64'd0);
    exp_addr_q.push_back(25'h0100246);
    strobe1(1, 18'h00123);
    wait_req(10, n);
    check("post_rst_refetch", 64'(n), 64'd1);
    serve(1, 16'h5555);
    idle(3);
    check("final_busy", 64'(ch_busy), 64'd0);
    check("final_queues", 64'(exp_addr_q.size() + exp_cpl_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_rom_sdr_arbiter.md
Name: tile_rom_sdr_arbiter

Overview:
- Multi-channel tile/sprite ROM fetch engine. It shares one SDRAM ROM port among NCH graphics layers (BACK1, BACK2, FRONT, OBJ).
- Generalises the single-layer "fetch on address change" request generator.
- Adds per-channel hit suppression, latest-wins pending requests, round-robin arbitration and a response timeout with automatic re-issue.
- Sits between the layer pixel pipelines and the SDRAM controller's ROM read port.

Parameters:
- NCH, 4, number of requesting channels (1..8).
- REQ_AW, 18, channel-local word address width.
- ADDR_W, 25, SDRAM byte address width.
- DATA_W, 16, SDRAM/ROM data width.
- BASE_ADDR, {NCH{25'h0}}, packed NCH*ADDR_W per-channel ROM region base; channel i occupies bits [i*ADDR_W +: ADDR_W].
- TIMEOUT, 64, cycles in WAIT without sdr_rdy before re-issue; must be ≥2.

Ports:
- clk, in, 1, single system clock; all logic on posedge.
- RESETn, in, 1, asynchronous active-low reset.
- ch_strobe, in, NCH, 1-cycle fetch request per channel.
- ch_addr, in, NCH*REQ_AW, word address per channel; sampled with ch_strobe.
- ch_data, out, NCH*DATA_W, last fetched word per channel; held until the next completion.
- ch_valid, out, NCH, 1-cycle pulse: ch_data updated, or hit acknowledged.
- ch_busy, out, NCH, channel has a pending or in-flight fetch.
- sdr_addr, out, ADDR_W, byte address = BASE_ADDR[g] | {ch_addr, 1'b0}.
- sdr_req, out, 1, 1-cycle request pulse.
- sdr_rdy, in, 1, 1-cycle data-valid pulse from the SDRAM controller.
- sdr_data, in, DATA_W, read data; valid with sdr_rdy.

Behaviour:
- Reset (async, immediate):
  - sdr_req=0, sdr_addr=0, ch_valid=0, ch_busy=0, ch_data=0.
  - All pend_valid, last_valid and inflight flags cleared; FSM=IDLE; rr_ptr=0; timeout counter=0.
  - Reset mid-WAIT abandons the fetch. A later sdr_rdy is ignored because the FSM is in IDLE.
- Per-channel bookkeeping: pend_valid, pend_addr, last_valid, last_addr.
- Strobe on channel i with address A, first matching rule applies:
  1. A equals the in-flight address of i: merged. No new pending; a single ch_valid fires at completion.
  2. last_valid && A==last_addr && !pend_valid: hit. No SDRAM access; ch_valid[i] pulses the next cycle and ch_data is unchanged.
  3. Otherwise: pend_valid<=1, pend_addr<=A. This overwrites any older pending address (latest-wins); the old request is dropped silently.
- Strobe on the same cycle its channel is granted: the grant consumes the old pend_addr, and the strobe re-sets pending (strobe wins).
- ch_busy[i] = pend_valid[i] | inflight[i].
- FSM, 2 states:
  - IDLE:
    - If any pend_valid, grant g = the first set channel at or after rr_ptr, cyclic.
    - Register sdr_addr and sdr_req=1 for exactly one cycle.
    - Clear pend_valid[g], set inflight[g], store the in-flight address, set rr_ptr=g+1 mod NCH.
    - Go to WAIT; timeout counter=0.
    - sdr_rdy in IDLE is ignored.
  - WAIT:
    - On sdr_rdy: ch_data[g]<=sdr_data, ch_valid[g] pulses the next cycle, last_addr[g]<=in-flight address, last_valid[g]<=1, inflight[g]<=0, go to IDLE.
    - Otherwise increment the counter. When it reaches TIMEOUT-1, re-pulse sdr_req with the same sdr_addr and clear the counter. Retries are unlimited.
- Latency: strobe in cycle t with the FSM idle gives sdr_req high in cycle t+2. The earliest completion is ch_valid in the cycle after sdr_rdy.
- Back-to-back: a new grant can issue in the cycle after the IDLE return. Minimum request spacing is 2 cycles from the sdr_rdy cycle.
- Width rules:
  - The address OR is done at ADDR_W; {ch_addr,1'b0} is zero-extended.
  - BASE_ADDR low REQ_AW+1 bits must be zero; this is not checked in RTL, and overlapping bits are simply OR'd.
- NCH=1: round-robin degenerates; rr_ptr stays 0.
- Only one transaction is outstanding at any time; sdr_req never pulses while a response is owed, except for a timeout re-issue.

Test Plan:
- Single fetch: NCH=4, strobe ch1 addr 0x00123, BASE_ADDR[1]=0x0100000 -> sdr_req at t+2 with sdr_addr=0x0100246; sdr_rdy with 0xBEEF -> ch_data[1]=0xBEEF, ch_valid[1] one pulse, ch_busy[1] falls.
- Hit suppression: repeat strobe ch1 addr 0x00123 after completion -> no sdr_req; ch_valid[1] pulses next cycle; ch_data[1] stays 0xBEEF.
- Round-robin: strobes on ch0, ch2, ch3 in the same cycle, rr_ptr=2 -> grant order 2, 3, 0; each sdr_req only after the prior sdr_rdy.
- Latest-wins and merge:
  - While ch0 is in-flight at 0x10, strobe ch0 0x20 then 0x30 -> exactly one later fetch, at 0x30.
  - Strobe ch0 0x10 during flight -> merged; a single ch_valid.
- Timeout: withhold sdr_rdy, TIMEOUT=8 -> sdr_req re-pulses every 8 cycles with the same addr; rdy on the 3rd attempt completes normally.
- Reset mid-WAIT: assert RESETn=0 while in flight -> all outputs 0 immediately; a late sdr_rdy after release causes no ch_valid; the next strobe at the old address fetches (last_valid cleared).
